// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch unit: branch format code, instruction
// field positions, condition and mode encodings, and the redirect FSM states.
//
// Instruction field map (LSB first):
//   [1:0]   format   (2'b10 = branch)
//   [3:2]   cond     (cond_e)
//   [11:4]  offset   (8-bit absolute target or signed PC-relative offset)
//   [13:12] mode     (mode_e)
// -----------------------------------------------------------------------------
package branch_pkg;

  localparam logic [1:0] FMT_BRANCH = 2'b10;

  localparam int FMT_LSB  = 0;
  localparam int COND_LSB = 2;
  localparam int OFF_LSB  = 4;
  localparam int OFF_W    = 8;
  localparam int MODE_LSB = 12;

  typedef enum logic [1:0] {
    COND_Z      = 2'b00,  // creg == 0
    COND_ONE    = 2'b01,  // creg == 1
    COND_TWO    = 2'b10,  // creg == 2
    COND_ALWAYS = 2'b11
  } cond_e;

  typedef enum logic [1:0] {
    MODE_ABS  = 2'b00,
    MODE_REL  = 2'b01,
    MODE_CALL = 2'b10,
    MODE_RET  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_e;

endpackage

// File: rtl/branch_unit_if.sv
// -----------------------------------------------------------------------------
// branch_unit_if
// Bundle between fetch / decode-execute and the branch unit.
//   run        fetch -> unit   instruction on memory_out is valid
//   memory_out fetch -> unit   current instruction
//   creg       exec  -> unit   compare result register
//   pc         unit  -> fetch  registered program counter
//   runo       unit  -> exec   unit accepts an instruction this cycle
//   flush      unit  -> exec   discard the instruction behind a taken branch
//   ras_err    unit  -> exec   sticky return-stack overflow/underflow
//   taken_cnt, nottaken_cnt    only when BRANCH_STATS_EN is defined
// Parameters must match those of the branch_unit instance it connects to.
// -----------------------------------------------------------------------------
interface branch_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int CREG_W  = 16
);

  logic               run;
  logic [INSTR_W-1:0] memory_out;
  logic [CREG_W-1:0]  creg;
  logic [PC_W-1:0]    pc;
  logic               runo;
  logic               flush;
  logic               ras_err;

`ifdef BRANCH_STATS_EN
  logic [15:0]        taken_cnt;
  logic [15:0]        nottaken_cnt;

  modport master (
    output run, memory_out, creg,
    input  pc, runo, flush, ras_err, taken_cnt, nottaken_cnt
  );

  modport slave (
    input  run, memory_out, creg,
    output pc, runo, flush, ras_err, taken_cnt, nottaken_cnt
  );
`else
  modport master (
    output run, memory_out, creg,
    input  pc, runo, flush, ras_err
  );

  modport slave (
    input  run, memory_out, creg,
    output pc, runo, flush, ras_err
  );
`endif

endinterface

// File: rtl/branch_ras.sv
// -----------------------------------------------------------------------------
// branch_ras
// Return-address stack (LIFO). Pushes while full and pops while empty are
// ignored; the caller detects those cases through full/empty.
//   clk, rst_n  clock, synchronous active-low reset (empties the stack)
//   push        write push_data on top
//   pop         discard the top entry
//   full/empty  occupancy status
//   top         most recently pushed entry (undefined when empty)
// -----------------------------------------------------------------------------
module branch_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] IDX_ONE = PTR_W'(1);

  // count_q has one extra bit so that "full" is distinguishable from "empty".
  logic [PTR_W:0]   count_q;
  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] top_idx;

  assign full    = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign wr_idx  = count_q[PTR_W-1:0];
  assign top_idx = wr_idx - IDX_ONE;
  assign top     = mem_q[top_idx];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (push && !full) begin
      count_q <= count_q + 1'b1;
    end else if (pop && !empty) begin
      count_q <= count_q - 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q alone defines
  // which entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
// Owns the program counter. Resolves branches against the compare register,
// supports absolute, PC-relative, CALL and RET targets, and inserts a
// one-cycle redirect bubble (runo low, flush high) after every taken branch.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    branch_unit_if.slave (run, memory_out, creg in; pc, runo, flush,
//          ras_err out; taken_cnt/nottaken_cnt with BRANCH_STATS_EN)
// Optional feature macro: BRANCH_STATS_EN adds saturating taken / not-taken
// branch counters.
// -----------------------------------------------------------------------------
module branch_unit
  import branch_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int INSTR_W   = 16,
  parameter int CREG_W    = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  branch_unit_if.slave bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ras_err_q;

  logic [INSTR_W-1:0] instr;
  logic [OFF_W-1:0]   offset;
  cond_e              cond;
  mode_e              mode;
  logic               is_branch, cond_true, accept, br_hit;
  logic               taken, not_taken, ras_fault;
  logic               push, pop, ras_full, ras_empty;
  logic [PC_W-1:0]    pc_inc, target, ras_top;

  assign instr  = bus.memory_out;
  assign offset = instr[OFF_LSB +: OFF_W];
  assign cond   = cond_e'(instr[COND_LSB +: 2]);
  assign mode   = mode_e'(instr[MODE_LSB +: 2]);

  generate
    if (INSTR_W > 14) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^instr[INSTR_W-1:14];
    end
  endgenerate

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    is_branch = (instr[FMT_LSB +: 2] == FMT_BRANCH);
    cond_true = 1'b0;
    case (cond)
      COND_Z:      cond_true = (bus.creg == CREG_W'(0));
      COND_ONE:    cond_true = (bus.creg == CREG_W'(1));
      COND_TWO:    cond_true = (bus.creg == CREG_W'(2));
      COND_ALWAYS: cond_true = 1'b1;
      default:     cond_true = 1'b0;
    endcase

    accept = bus.run && (state_q == ST_RUN);
    br_hit = accept && is_branch && cond_true;

    // A RET with nothing to return to degrades to a not-taken branch.
    taken     = br_hit && !((mode == MODE_RET) && ras_empty);
    not_taken = accept && is_branch && !taken;
    push      = br_hit && (mode == MODE_CALL) && !ras_full;
    pop       = br_hit && (mode == MODE_RET) && !ras_empty;
    ras_fault = br_hit && (((mode == MODE_CALL) && ras_full) ||
                           ((mode == MODE_RET) && ras_empty));

    pc_inc = pc_q + 1'b1;
    target = PC_W'(offset);
    case (mode)
      MODE_ABS:  target = PC_W'(offset);
      MODE_REL:  target = pc_q + PC_W'(signed'(offset));
      MODE_CALL: target = PC_W'(offset);
      MODE_RET:  target = ras_top;
      default:   target = PC_W'(offset);
    endcase

    pc_d = pc_q;
    if (accept) begin
      pc_d = taken ? target : pc_inc;
    end
  end

  // Redirect FSM: a taken branch costs exactly one bubble cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (taken) state_d = ST_BUBBLE;
      ST_BUBBLE: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc_q      <= '0;
      ras_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (ras_fault) ras_err_q <= 1'b1;
    end
  end

  branch_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .full      (ras_full),
    .empty     (ras_empty),
    .top       (ras_top)
  );

  assign bus.pc      = pc_q;
  assign bus.runo    = (state_q == ST_RUN);
  assign bus.flush   = (state_q == ST_BUBBLE);
  assign bus.ras_err = ras_err_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, nottaken_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else begin
      if (taken && (taken_cnt_q != 16'hFFFF))
        taken_cnt_q <= taken_cnt_q + 1'b1;
      if (not_taken && (nottaken_cnt_q != 16'hFFFF))
        nottaken_cnt_q <= nottaken_cnt_q + 1'b1;
    end
  end

  assign bus.taken_cnt    = taken_cnt_q;
  assign bus.nottaken_cnt = nottaken_cnt_q;
`else
  logic unused_not_taken;
  assign unused_not_taken = not_taken;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_unit
// Directed testbench for branch_unit (PC_W=8, INSTR_W=16, CREG_W=16,
// RAS_DEPTH=4). Inputs change 1 ns after the rising edge and outputs are
// sampled at the same point, well away from the active edge.
// Counter checks are compiled in only when BRANCH_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_branch_unit;
  import branch_pkg::*;

  localparam logic [15:0] NOP = 16'h0000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  branch_unit_if #(.PC_W(8), .INSTR_W(16), .CREG_W(16)) bus ();

  branch_unit #(
    .PC_W      (8),
    .INSTR_W   (16),
    .CREG_W    (16),
    .RAS_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] br(input mode_e m, input cond_e c,
                                     input logic [7:0] off);
    return {2'b00, m, off, c, FMT_BRANCH};
  endfunction

  // One clock: apply inputs, cross the rising edge, settle.
  task automatic step(input logic r, input logic [15:0] ins,
                      input logic [15:0] c);
    bus.run        = r;
    bus.memory_out = ins;
    bus.creg       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, NOP, 16'h0);
    step(1'b0, NOP, 16'h0);
    rst_n = 1'b1;
  endtask

  // Unconditional absolute jump followed by its bubble cycle.
  task automatic jump_to(input logic [7:0] a);
    step(1'b1, br(MODE_ABS, COND_ALWAYS, a), 16'h0);
    step(1'b1, NOP, 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.memory_out = NOP;
    bus.creg = '0;
    do_reset();
    check("reset_pc", bus.pc, 8'h00);
    check("reset_runo", bus.runo, 1'b1);
    check("reset_flush", bus.flush, 1'b0);
    check("reset_ras_err", bus.ras_err, 1'b0);

    // Sequential fetch.
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, NOP, 16'h0);
      check($sformatf("seq_pc%0d", i), bus.pc, 32'(i));
      check($sformatf("seq_runo%0d", i), bus.runo, 1'b1);
      check($sformatf("seq_flush%0d", i), bus.flush, 1'b0);
    end

    // No accept: branch presented with run low must not move the pc.
    step(1'b0, br(MODE_ABS, COND_ALWAYS, 8'h77), 16'h0);
    check("hold_pc", bus.pc, 8'h03);
    check("hold_runo", bus.runo, 1'b1);

    step(1'b1, NOP, 16'h0);
    step(1'b1, NOP, 16'h0);
    check("pc_at_5", bus.pc, 8'h05);

    // ABS taken on creg==0, bubble, then run during the bubble is ignored.
    step(1'b1, br(MODE_ABS, COND_Z, 8'h40), 16'h0);
    check("abs_pc", bus.pc, 8'h40);
    check("abs_bubble_runo", bus.runo, 1'b0);
    check("abs_bubble_flush", bus.flush, 1'b1);
    step(1'b1, NOP, 16'h0);
    check("abs_after_pc", bus.pc, 8'h40);
    check("abs_after_runo", bus.runo, 1'b1);
    check("abs_after_flush", bus.flush, 1'b0);

    // Same ABS with creg=3: not taken, no bubble.
    jump_to(8'h05);
    step(1'b1, br(MODE_ABS, COND_Z, 8'h40), 16'h3);
    check("nt_pc", bus.pc, 8'h06);
    check("nt_runo", bus.runo, 1'b1);
    check("nt_flush", bus.flush, 1'b0);

    // Full-width compare: creg=0x0100 is not zero.
    step(1'b1, br(MODE_ABS, COND_Z, 8'h40), 16'h0100);
    check("wide_creg_pc", bus.pc, 8'h07);
    // creg==1 and creg==2 conditions.
    step(1'b1, br(MODE_ABS, COND_ONE, 8'h60), 16'h1);
    check("cond_one_pc", bus.pc, 8'h60);
    step(1'b1, NOP, 16'h0);
    step(1'b1, br(MODE_ABS, COND_TWO, 8'h70), 16'h1);
    check("cond_two_nt_pc", bus.pc, 8'h61);
    step(1'b1, br(MODE_ABS, COND_TWO, 8'h70), 16'h2);
    check("cond_two_pc", bus.pc, 8'h70);
    step(1'b1, NOP, 16'h0);

    // PC-relative, backwards and with wrap.
    jump_to(8'h10);
    step(1'b1, br(MODE_REL, COND_ALWAYS, 8'hFC), 16'h0);
    check("rel_back_pc", bus.pc, 8'h0C);
    check("rel_back_flush", bus.flush, 1'b1);
    step(1'b1, NOP, 16'h0);
    jump_to(8'hFE);
    step(1'b1, br(MODE_REL, COND_ALWAYS, 8'h05), 16'h0);
    check("rel_wrap_pc", bus.pc, 8'h03);
    step(1'b1, NOP, 16'h0);

    // CALL / RET.
    jump_to(8'h20);
    step(1'b1, br(MODE_CALL, COND_ALWAYS, 8'h80), 16'h0);
    check("call_pc", bus.pc, 8'h80);
    check("call_flush", bus.flush, 1'b1);
    step(1'b1, NOP, 16'h0);
    step(1'b1, br(MODE_RET, COND_ALWAYS, 8'h00), 16'h0);
    check("ret_pc", bus.pc, 8'h21);
    check("ret_flush", bus.flush, 1'b1);
    step(1'b1, NOP, 16'h0);
    check("ret_ras_err", bus.ras_err, 1'b0);

    // Five nested CALLs into a 4-deep stack; pushes 0x22, 0x91, 0xA1, 0xB1.
    step(1'b1, br(MODE_CALL, COND_ALWAYS, 8'h90), 16'h0);
    step(1'b1, NOP, 16'h0);
    step(1'b1, br(MODE_CALL, COND_ALWAYS, 8'hA0), 16'h0);
    step(1'b1, NOP, 16'h0);
    step(1'b1, br(MODE_CALL, COND_ALWAYS, 8'hB0), 16'h0);
    step(1'b1, NOP, 16'h0);
    step(1'b1, br(MODE_CALL, COND_ALWAYS, 8'hC0), 16'h0);
    check("call4_ras_err", bus.ras_err, 1'b0);
    step(1'b1, NOP, 16'h0);
    step(1'b1, br(MODE_CALL, COND_ALWAYS, 8'hD0), 16'h0);
    check("call5_pc", bus.pc, 8'hD0);
    check("call5_ras_err", bus.ras_err, 1'b1);
    check("call5_flush", bus.flush, 1'b1);
    step(1'b1, NOP, 16'h0);
    step(1'b1, br(MODE_RET, COND_ALWAYS, 8'h00), 16'h0);
    check("ret_after_ovf_pc", bus.pc, 8'hB1);
    step(1'b1, NOP, 16'h0);

    // RET on an empty stack.
    do_reset();
    jump_to(8'h30);
    step(1'b1, br(MODE_RET, COND_ALWAYS, 8'h00), 16'h0);
    check("ret_empty_pc", bus.pc, 8'h31);
    check("ret_empty_runo", bus.runo, 1'b1);
    check("ret_empty_flush", bus.flush, 1'b0);
    check("ret_empty_ras_err", bus.ras_err, 1'b1);

    // Reset asserted during a bubble.
    step(1'b1, br(MODE_ABS, COND_ALWAYS, 8'h50), 16'h0);
    check("pre_rst_runo", bus.runo, 1'b0);
    rst_n = 1'b0;
    step(1'b1, NOP, 16'h0);
    check("rst_bubble_pc", bus.pc, 8'h00);
    check("rst_bubble_runo", bus.runo, 1'b1);
    check("rst_bubble_flush", bus.flush, 1'b0);
    check("rst_bubble_ras_err", bus.ras_err, 1'b0);
    rst_n = 1'b1;

`ifdef BRANCH_STATS_EN
    do_reset();
    check("stats_reset_taken", bus.taken_cnt, 16'h0);
    jump_to(8'h10);
    jump_to(8'h20);
    step(1'b1, br(MODE_ABS, COND_Z, 8'h40), 16'h5);
    check("stats_taken", bus.taken_cnt, 16'h2);
    check("stats_nottaken", bus.nottaken_cnt, 16'h1);
    step(1'b1, br(MODE_RET, COND_ALWAYS, 8'h00), 16'h0);
    check("stats_ret_empty_nt", bus.nottaken_cnt, 16'h2);
    force dut.taken_cnt_q = 16'hFFFF;
    #1;
    release dut.taken_cnt_q;
    jump_to(8'h30);
    check("stats_saturate", bus.taken_cnt, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Parametrised successor to the combinational branch resolver; owns the program counter for the 16-bit core.
- Resolves branch instructions against the compare register and keeps the PC registered.
- Adds PC-relative branches, an unconditional condition code, CALL/RET through an internal return-address stack (RAS), and a one-cycle redirect bubble handshake.
- Sits between instruction memory output (fetch) and the decode/execute stage, which it stalls via runo.

Parameters:
- PC_W, 8, program counter width (8..16).
- INSTR_W, 16, instruction width (fixed field map below; must be ≥14).
- CREG_W, 16, compare register width.
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- run  in  1  instruction on memory_out is valid this cycle.
- memory_out  in  INSTR_W  current instruction.
- creg  in  CREG_W  compare result register.
- pc  out  PC_W  registered program counter (fetch address).
- runo  out  1  unit accepts an instruction this cycle; low during redirect bubble.
- flush  out  1  one-cycle pulse: the instruction fetched behind a taken branch must be discarded.
- ras_err  out  1  sticky RAS overflow/underflow flag.

Behaviour:
- Reset (rst_n=0 at posedge): pc=0, runo=1, flush=0, ras_err=0, RAS pointer=0, contents don't-care. Reset mid-bubble or mid-stack cancels everything.
- Fields: format=[1:0], cond=[3:2], offset=[11:4], mode=[13:12]; branch when format==2'b10.
- Accept when run && runo. No accept: all state holds.
- Non-branch accept: pc<=pc+1 (wraps mod 2^PC_W).
- Conditions: 00 creg==0; 01 creg==1; 10 creg==2; 11 always. Compare uses full CREG_W.
- Modes, when the condition is true (taken):
  - 00 ABS: target = zero-extended offset.
  - 01 REL: target = pc + sign-extended offset, mod 2^PC_W.
  - 10 CALL: push pc+1, target = zero-extended offset.
  - 11 RET: pop, target = popped value.
- Not taken: pc<=pc+1, no push/pop, no bubble.
- Taken: pc<=target at the accepting edge. On the next cycle runo=0 and flush=1 for exactly one cycle, then runo=1.
- Latency: redirect visible on pc one cycle after accept. Taken branch costs one bubble.
- CALL when RAS full: push dropped, ras_err<=1, jump still taken.
- RET when RAS empty: treated as not taken (pc+1, no bubble), ras_err<=1.
- ras_err clears only on reset.
- run during bubble is ignored; the upstream stage must hold the instruction.

Optional Feature:
- BRANCH_STATS_EN defined: adds outputs taken_cnt[15:0] and nottaken_cnt[15:0].
  - Each increments on a taken / not-taken branch accept.
  - Both saturate at 16'hFFFF and reset to 0.
  - An empty-RAS RET counts as not-taken.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package branch_pkg: FMT_BRANCH=2'b10; cond enum (COND_Z, COND_ONE, COND_TWO, COND_ALWAYS); mode enum (MODE_ABS, MODE_REL, MODE_CALL, MODE_RET); field bit-position constants.
- Sub-module branch_ras: parametrised LIFO (push, pop, full, empty, top) with synchronous active-low reset.
- Condition/target evaluation stays combinational inside branch_unit.

Test Plan:
- Reset, then 3 non-branch instrs with run=1 -> pc 0,1,2,3; runo=1 throughout; flush never high.
- At pc=5, ABS cond=00 offset=0x40, creg=0 -> pc=0x40 next cycle; runo=0/flush=1 for one cycle. Same with creg=3 -> pc=6, no bubble.
- At pc=0x10, REL cond=11 offset=0xFC -> pc=0x0C. At pc=0xFE, offset=0x05 -> pc=0x03 (wrap).
- CALL at pc=0x20 to 0x80, then RET -> pc=0x80, then 0x21. Five nested CALLs with depth 4 -> ras_err=1 on the 5th; jump still taken.
- RET on empty RAS at pc=0x30 -> pc=0x31, no bubble, ras_err=1. Assert rst_n=0 during a bubble -> pc=0, runo=1, flush=0, ras_err=0 next cycle.
- With BRANCH_STATS_EN: 2 taken + 1 not-taken branch -> taken_cnt=2, nottaken_cnt=1. Force counter to 0xFFFF, take one more -> stays 0xFFFF.
